// File: rtl/autotest_result_packer.sv
// Packs a captured UUT result into one SD block write: result bytes MSB first, then padding.
// Define AUTOTEST_PACKER_CRC8_EN to insert a CRC-8 (poly 0x07) byte right after the result.
module autotest_result_packer #(
    parameter int         OUTPUT_SIZE_1 = 32,
    parameter int         BLOCK_BYTES   = 512,
    parameter logic [7:0] PAD_BYTE      = 8'h00
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     capture,
    input  logic [OUTPUT_SIZE_1-1:0] result_in,
    input  logic [31:0]              block_addr_in,
    input  logic                     spi_busy,
    input  logic                     spi_err,
    output logic                     spi_w_block,
    output logic                     spi_w_byte,
    output logic [7:0]               spi_data_in,
    output logic [31:0]              spi_block_addr,
    output logic                     busy,
    output logic                     done,
    output logic                     err
);

    localparam logic [9:0] RESULT_BYTES = 10'(OUTPUT_SIZE_1 / 8);
    localparam logic [9:0] LAST_BYTE    = 10'(BLOCK_BYTES - 1);

    typedef enum logic [3:0] {
        IDLE, BLK_WAIT, BLK_STB, BLK_ACK, BYTE_WAIT,
        BYTE_STB, BYTE_ACK, NEXT, DONE, ERROR
    } state_t;

    state_t                   state;
    logic [9:0]               byte_cnt;
    logic [OUTPUT_SIZE_1-1:0] result_q;
    logic                     ack_seen;
    logic [7:0]               next_byte;

`ifdef AUTOTEST_PACKER_CRC8_EN
    logic [7:0] crc_q;

    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
        end
        return c;
    endfunction
`endif

    // Byte to present for the current counter position
    always_comb begin
        next_byte = PAD_BYTE;
        if (byte_cnt < RESULT_BYTES) begin
            next_byte = 8'(result_q >> {RESULT_BYTES - 10'd1 - byte_cnt, 3'b000});
        end
`ifdef AUTOTEST_PACKER_CRC8_EN
        else if (byte_cnt == RESULT_BYTES) begin
            next_byte = crc_q;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            byte_cnt       <= '0;
            result_q       <= '0;
            ack_seen       <= 1'b0;
            spi_w_block    <= 1'b0;
            spi_w_byte     <= 1'b0;
            spi_data_in    <= 8'h00;
            spi_block_addr <= 32'h0;
            busy           <= 1'b0;
            done           <= 1'b0;
            err            <= 1'b0;
`ifdef AUTOTEST_PACKER_CRC8_EN
            crc_q          <= 8'h00;
`endif
        end else begin
            spi_w_block <= 1'b0;
            spi_w_byte  <= 1'b0;
            // A host error wins over any busy handshake in the same cycle
            if (busy && spi_err) begin
                state <= ERROR;
                busy  <= 1'b0;
                err   <= 1'b1;
            end else begin
                case (state)
                    IDLE, DONE, ERROR: begin
                        if (capture) begin
                            result_q       <= result_in;
                            spi_block_addr <= block_addr_in;
                            byte_cnt       <= '0;
                            ack_seen       <= 1'b0;
                            busy           <= 1'b1;
                            done           <= 1'b0;
                            err            <= 1'b0;
                            state          <= BLK_WAIT;
`ifdef AUTOTEST_PACKER_CRC8_EN
                            crc_q          <= 8'h00;
`endif
                        end
                    end
                    BLK_WAIT: begin
                        if (!spi_busy) begin
                            state       <= BLK_STB;
                            spi_w_block <= 1'b1;
                        end
                    end
                    BLK_STB: begin
                        state    <= BLK_ACK;
                        ack_seen <= 1'b0;
                    end
                    BLK_ACK: begin
                        if (spi_busy) ack_seen <= 1'b1;
                        else if (ack_seen) state <= BYTE_WAIT;
                    end
                    BYTE_WAIT: begin
                        if (!spi_busy) begin
                            state       <= BYTE_STB;
                            spi_w_byte  <= 1'b1;
                            spi_data_in <= next_byte;
`ifdef AUTOTEST_PACKER_CRC8_EN
                            if (byte_cnt < RESULT_BYTES) crc_q <= crc8_step(crc_q, next_byte);
`endif
                        end
                    end
                    BYTE_STB: begin
                        state    <= BYTE_ACK;
                        ack_seen <= 1'b0;
                    end
                    BYTE_ACK: begin
                        if (spi_busy) ack_seen <= 1'b1;
                        else if (ack_seen) state <= NEXT;
                    end
                    NEXT: begin
                        byte_cnt <= byte_cnt + 10'd1;
                        if (byte_cnt == LAST_BYTE) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state <= BYTE_WAIT;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_autotest_result_packer.sv
// Randomized bench for autotest_result_packer with a byte-stream reference model and a 3-cycle SD host model.
// Honours AUTOTEST_PACKER_CRC8_EN when building the expected block contents.
module tb_autotest_result_packer;

    localparam int         OUT_W = 32;
    localparam int         NB    = OUT_W / 8;
    localparam int         BLK   = 512;
    localparam logic [7:0] PAD   = 8'h00;

    logic             clk;
    logic             rst;
    logic             capture;
    logic [OUT_W-1:0] result_in;
    logic [31:0]      block_addr_in;
    logic             spi_busy;
    logic             spi_err;
    logic             spi_w_block;
    logic             spi_w_byte;
    logic [7:0]       spi_data_in;
    logic [31:0]      spi_block_addr;
    logic             busy;
    logic             done;
    logic             err;

    int         total;
    int         bad;
    bit         started;
    bit         active;
    int         idx;
    int         blk_count;
    logic [31:0] exp_addr;
    logic [7:0] exp_bytes [BLK];
    bit         slave_busy;
    int         slave_rem;
    bit         last_op_byte;
    bit         hold_busy;

    assign spi_busy = slave_busy | hold_busy;

    autotest_result_packer #(
        .OUTPUT_SIZE_1(OUT_W),
        .BLOCK_BYTES  (BLK),
        .PAD_BYTE     (PAD)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .capture       (capture),
        .result_in     (result_in),
        .block_addr_in (block_addr_in),
        .spi_busy      (spi_busy),
        .spi_err       (spi_err),
        .spi_w_block   (spi_w_block),
        .spi_w_byte    (spi_w_byte),
        .spi_data_in   (spi_data_in),
        .spi_block_addr(spi_block_addr),
        .busy          (busy),
        .done          (done),
        .err           (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // CRC as the remainder of (message * x^8) divided by x^8+x^2+x+1
    function automatic logic [7:0] crc_model(input logic [OUT_W-1:0] res);
        logic [OUT_W+7:0] r;
        r = {res, 8'h00};
        for (int b = OUT_W + 7; b >= 8; b--) begin
            if (r[b]) r = r ^ ((OUT_W+8)'(9'h107) << (b - 8));
        end
        return r[7:0];
    endfunction

    function automatic void build_expected(input logic [OUT_W-1:0] res);
        for (int i = 0; i < BLK; i++) begin
            if (i < NB) exp_bytes[i] = 8'(res >> (8 * (NB - 1 - i)));
            else        exp_bytes[i] = PAD;
        end
`ifdef AUTOTEST_PACKER_CRC8_EN
        exp_bytes[NB] = crc_model(res);
`endif
    endfunction

    // Compare process plus SD host model: each strobe makes the host busy for 3 cycles
    always @(negedge clk) begin
        if (!rst) begin
            if (started) begin
                check_output("reset_ctrl", {27'd0, spi_w_block, spi_w_byte, busy, done, err}, 32'd0);
                check_output("reset_data", {24'd0, spi_data_in}, 32'd0);
                check_output("reset_addr", spi_block_addr, 32'd0);
            end
            slave_busy = 1'b0;
            slave_rem  = 0;
        end else begin
            if (spi_w_block) begin
                check_output("blk_strobe_legal", 32'(active && blk_count == 0 && !spi_w_byte), 32'd1);
                blk_count++;
                last_op_byte = 1'b0;
            end
            if (spi_w_byte) begin
                check_output("byte_strobe_legal", 32'(active && blk_count == 1 && idx < BLK), 32'd1);
                if (idx < BLK) check_output($sformatf("byte_value[%0d]", idx), {24'd0, spi_data_in}, {24'd0, exp_bytes[idx]});
                idx++;
                last_op_byte = 1'b1;
            end else if (slave_busy && last_op_byte && active && idx > 0 && idx <= BLK) begin
                check_output("data_hold", {24'd0, spi_data_in}, {24'd0, exp_bytes[idx-1]});
            end
            check_output("block_addr", spi_block_addr, exp_addr);
            if (spi_w_block || spi_w_byte) slave_rem = 3;
            if (slave_rem > 0) begin
                slave_busy = 1'b1;
                slave_rem--;
            end else begin
                slave_busy = 1'b0;
            end
        end
    end

    task automatic apply_stimulus(input logic [OUT_W-1:0] res, input logic [31:0] addr);
        bit accept;
        @(posedge clk);
        #1;
        result_in     = res;
        block_addr_in = addr;
        capture       = 1'b1;
        accept        = !active;
        @(posedge clk);
        #1;
        capture = 1'b0;
        if (accept) begin
            active    = 1'b1;
            idx       = 0;
            blk_count = 0;
            exp_addr  = addr;
            build_expected(res);
        end
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (done !== 1'b1 && n < 8000) begin
            @(negedge clk);
            n++;
        end
        check_output("done_reached", {31'd0, done}, 32'd1);
        check_output("bytes_sent", idx, BLK);
        check_output("blk_strobes", blk_count, 1);
        check_output("done_addr", spi_block_addr, exp_addr);
        check_output("done_flags", {30'd0, busy, err}, 32'd0);
        active = 1'b0;
    endtask

    task automatic wait_bytes(input int count);
        int n;
        n = 0;
        while (idx < count && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_output("byte_progress", 32'(idx >= count), 32'd1);
    endtask

    initial begin
        int held_idx;
        total = 0; bad = 0; started = 0; active = 0; idx = 0; blk_count = 0;
        exp_addr = 32'h0; slave_busy = 0; slave_rem = 0; last_op_byte = 0; hold_busy = 0;
        capture = 0; result_in = '0; block_addr_in = 32'h0; spi_err = 0;
        rst = 1'b1;
        #3 rst = 1'b0;
        started = 1'b1;
        repeat (3) @(negedge clk);
        check_output("reset_busy_done_err", {29'd0, busy, done, err}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;

        // Known result: pins the model against hand-computed bytes
        apply_stimulus(32'hDEADBEEF, 32'h10);
        check_output("model_b0", {24'd0, exp_bytes[0]}, 32'hDE);
        check_output("model_b1", {24'd0, exp_bytes[1]}, 32'hAD);
        check_output("model_b3", {24'd0, exp_bytes[3]}, 32'hEF);
`ifdef AUTOTEST_PACKER_CRC8_EN
        check_output("model_crc", {24'd0, exp_bytes[4]}, 32'hCA);
`else
        check_output("model_b4_pad", {24'd0, exp_bytes[4]}, 32'h00);
`endif
        check_output("model_last_pad", {24'd0, exp_bytes[BLK-1]}, 32'h00);
        @(negedge clk);
        check_output("busy_after_capture", {29'd0, busy, done, err}, 32'b100);
        repeat (40) @(posedge clk);
        apply_stimulus(32'h12345678, 32'h99);
        wait_done();
        check_output("addr_literal", spi_block_addr, 32'h10);

        // Host held busy: block strobe must wait for it
        hold_busy = 1'b1;
        apply_stimulus($urandom, $urandom);
        repeat (20) @(negedge clk);
        check_output("no_blk_while_busy", blk_count, 0);
        check_output("busy_while_held", {31'd0, busy}, 32'd1);
        @(posedge clk);
        #1 hold_busy = 1'b0;
        wait_done();

        // Host error during a byte acknowledge
        apply_stimulus($urandom, $urandom);
        wait_bytes(3);
        spi_err = 1'b1;
        active  = 1'b0;
        @(posedge clk);
        #1 spi_err = 1'b0;
        @(negedge clk);
        check_output("err_next_cycle", {29'd0, busy, done, err}, 32'b001);
        held_idx = idx;
        repeat (20) @(negedge clk);
        check_output("err_sticky", {31'd0, err}, 32'd1);
        check_output("no_strobes_after_err", idx, held_idx);
        apply_stimulus($urandom, $urandom);
        @(negedge clk);
        check_output("err_cleared", {29'd0, busy, done, err}, 32'b100);
        wait_done();

        // Reset in the middle of a block
        apply_stimulus($urandom, $urandom);
        wait_bytes(100);
        rst      = 1'b0;
        active   = 1'b0;
        exp_addr = 32'h0;
        #1;
        check_output("async_reset_ctrl", {27'd0, spi_w_block, spi_w_byte, busy, done, err}, 32'd0);
        check_output("async_reset_data", {24'd0, spi_data_in}, 32'd0);
        check_output("async_reset_addr", spi_block_addr, 32'd0);
        held_idx = idx;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        repeat (30) @(negedge clk);
        check_output("idle_after_reset", {29'd0, busy, done, err}, 32'd0);
        check_output("no_strobes_after_reset", idx, held_idx);

        // Random full blocks
        for (int t = 0; t < 2; t++) begin
            apply_stimulus($urandom, $urandom);
            wait_done();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
